// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg
//   Shared definitions for the programmable I/O bank: width of one channel's
//   configuration slice, bit positions of its fields inside that slice, and
//   the edge-detector mode encoding.
package gpio_bank_pkg;

  localparam int CFG_BITS    = 4;
  localparam int CFG_DIR     = 0;
  localparam int CFG_OREG    = 1;
  localparam int CFG_EDGE_LO = 2;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // True when the observed transition qualifies for the selected mode.
  function automatic logic edge_hit(edge_mode_e mode, logic rise, logic fall);
    logic hit;
    case (mode)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/gpio_channel.sv
// gpio_channel
//   One pad channel of the I/O bank.
//   Ports:
//     CK, RST        clock (rising edge), asynchronous active-low reset
//     prog_en        1 = configuration shift mode (pad released, no events)
//     i_chain        serial config bit from the previous slice / chain head
//     o_chain        last bit of this slice, feeds the next slice
//     i_a            fabric-to-pad data
//     o_pad_out      value to drive on the pad
//     o_pad_oe       pad output enable (buffer lives in the top level)
//     i_pad          resolved pad level
//     o_y            synchronised pad level
//     o_evt          sticky edge-event flag
//     i_evt_clr      write-1-to-clear for o_evt
module gpio_channel
  import gpio_bank_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic CK,
  input  logic RST,
  input  logic prog_en,
  input  logic i_chain,
  output logic o_chain,
  input  logic i_a,
  output logic o_pad_out,
  output logic o_pad_oe,
  input  logic i_pad,
  output logic o_y,
  output logic o_evt,
  input  logic i_evt_clr
);

  logic [CFG_BITS-1:0]    r_cfg;
  logic                   r_oreg;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_evt;

  logic       w_y;
  logic       w_rise;
  logic       w_fall;
  logic       w_set;
  edge_mode_e w_edge;

  assign w_y    = r_sync[SYNC_STAGES-1];
  assign w_edge = edge_mode_e'(r_cfg[CFG_EDGE_LO +: 2]);
  assign w_rise = ~r_prev & w_y;
  assign w_fall = r_prev & ~w_y;
  // Events are suppressed while programming; prev keeps tracking Y so the
  // first cycle after programming does not see a stale transition.
  assign w_set  = ~prog_en & edge_hit(w_edge, w_rise, w_fall);

  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      r_cfg  <= '0;
      r_oreg <= 1'b0;
      r_sync <= '0;
      r_prev <= 1'b0;
      r_evt  <= 1'b0;
    end else begin
      if (prog_en) begin
        r_cfg <= {r_cfg[CFG_BITS-2:0], i_chain};
      end
      r_oreg <= i_a;
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
      r_prev <= w_y;
      // Set has priority over a simultaneous clear.
      r_evt  <= w_set | (r_evt & ~i_evt_clr);
    end
  end

  assign o_chain   = r_cfg[CFG_BITS-1];
  assign o_pad_oe  = r_cfg[CFG_DIR] & ~prog_en;
  assign o_pad_out = r_cfg[CFG_OREG] ? r_oreg : i_a;
  assign o_y       = w_y;
  assign o_evt     = r_evt;

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank
//   N_CH-channel programmable I/O bank. Each channel carries a 4-bit
//   configuration slice on a shared serial chain (channel c at chain bits
//   4c..4c+3), an optional output register, an input synchroniser and a
//   sticky edge detector.
//   Ports:
//     CK, RST              clock, asynchronous active-low reset
//     prog_en              1 = shift configuration chain, pads released
//     ccff_head/ccff_tail  serial configuration in / out
//     A                    fabric-to-pad data
//     Y                    synchronised pad-to-fabric data
//     EVT / EVT_CLR        sticky event flags / write-1-to-clear
//     PAD                  package pads
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            CK,
  input  logic            RST,
  input  logic            prog_en,
  input  logic            ccff_head,
  output logic            ccff_tail,
  input  logic [N_CH-1:0] A,
  output logic [N_CH-1:0] Y,
  output logic [N_CH-1:0] EVT,
  input  logic [N_CH-1:0] EVT_CLR,
  inout  wire  [N_CH-1:0] PAD
);

  // w_chain[c] enters slice c; w_chain[N_CH] is the chain tail.
  logic [N_CH:0]   w_chain;
  logic [N_CH-1:0] w_pad_out;
  logic [N_CH-1:0] w_pad_oe;

  assign w_chain[0] = ccff_head;
  assign ccff_tail  = w_chain[N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    gpio_channel #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .CK        (CK),
      .RST       (RST),
      .prog_en   (prog_en),
      .i_chain   (w_chain[gi]),
      .o_chain   (w_chain[gi+1]),
      .i_a       (A[gi]),
      .o_pad_out (w_pad_out[gi]),
      .o_pad_oe  (w_pad_oe[gi]),
      .i_pad     (PAD[gi]),
      .o_y       (Y[gi]),
      .o_evt     (EVT[gi]),
      .i_evt_clr (EVT_CLR[gi])
    );

    assign PAD[gi] = w_pad_oe[gi] ? w_pad_out[gi] : 1'bz;
  end

endmodule

// File: tb/tb_gpio_bank.sv
module tb_gpio_bank;

  localparam int N = 8;
  localparam int S = 2;
  localparam int L = 4 * N;

  logic         CK = 1'b0;
  logic         RST;
  logic         prog_en;
  logic         ccff_head;
  wire          ccff_tail;
  logic [N-1:0] A;
  wire  [N-1:0] Y;
  wire  [N-1:0] EVT;
  logic [N-1:0] EVT_CLR;
  wire  [N-1:0] PAD;

  // External pad drivers: the bench drives every pad the DUT should not.
  logic [N-1:0] tb_en;
  logic [N-1:0] tb_val;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state.
  logic [L-1:0] m_chain;
  logic [N-1:0] m_oreg;
  logic [N-1:0] m_evt;
  logic [N-1:0] m_hist[$];   // pad samples, newest first

  logic [L-1:0] cfg1, cfg2;

  always #5 CK = ~CK;

  for (genvar gi = 0; gi < N; gi++) begin : g_pad
    assign PAD[gi] = tb_en[gi] ? tb_val[gi] : 1'bz;
  end

  gpio_bank #(.N_CH(N), .SYNC_STAGES(S)) dut (
    .CK        (CK),
    .RST       (RST),
    .prog_en   (prog_en),
    .ccff_head (ccff_head),
    .ccff_tail (ccff_tail),
    .A         (A),
    .Y         (Y),
    .EVT       (EVT),
    .EVT_CLR   (EVT_CLR),
    .PAD       (PAD)
  );

  task automatic check(input string tag, input logic [L-1:0] got, input logic [L-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_drive();
    logic [N-1:0] d;
    for (int c = 0; c < N; c++) d[c] = m_chain[4*c] & ~prog_en;
    return d;
  endfunction

  function automatic logic [N-1:0] m_out();
    logic [N-1:0] o;
    for (int c = 0; c < N; c++) o[c] = m_chain[4*c+1] ? m_oreg[c] : A[c];
    return o;
  endfunction

  function automatic logic [N-1:0] exp_pad();
    return (m_drive() & m_out()) | (~m_drive() & tb_val);
  endfunction

  function automatic logic [L-1:0] set_ch(input logic [L-1:0] cfg, input int c,
                                          input logic dir, input logic oreg,
                                          input logic [1:0] md);
    logic [L-1:0] r;
    r = cfg;
    r[4*c]   = dir;
    r[4*c+1] = oreg;
    r[4*c+2] = md[0];
    r[4*c+3] = md[1];
    return r;
  endfunction

  task automatic m_reset();
    m_chain = '0;
    m_oreg  = '0;
    m_evt   = '0;
    m_hist.delete();
    for (int i = 0; i <= S; i++) m_hist.push_back('0);
  endtask

  // Advance one clock: update the model from the pre-edge view, then step.
  task automatic tick();
    logic [N-1:0] pv, y, p, rise, fall, set;
    logic [1:0]   md;
    tb_en = ~m_drive();
    #1;
    pv = exp_pad();
    y  = m_hist[S-1];
    p  = m_hist[S];
    rise = ~p & y;
    fall = p & ~y;
    set  = '0;
    for (int c = 0; c < N; c++) begin
      md = {m_chain[4*c+3], m_chain[4*c+2]};
      case (md)
        2'd1:    set[c] = rise[c];
        2'd2:    set[c] = fall[c];
        2'd3:    set[c] = rise[c] | fall[c];
        default: set[c] = 1'b0;
      endcase
      if (prog_en) set[c] = 1'b0;
    end
    m_evt = set | (m_evt & ~EVT_CLR);
    if (prog_en) m_chain = {m_chain[L-2:0], ccff_head};
    m_oreg = A;
    m_hist.push_front(pv);
    void'(m_hist.pop_back());
    @(posedge CK);
    #1;
    tb_en = ~m_drive();
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_y"},    Y,         m_hist[S-1]);
    check({tag, "_evt"},  EVT,       m_evt);
    check({tag, "_tail"}, ccff_tail, m_chain[L-1]);
    check({tag, "_pad"},  PAD,       exp_pad());
    $display("%s t=%0t prog=%b a=%h pad=%h y=%h evt=%h tail=%b",
             tag, $time, prog_en, A, PAD, Y, EVT, ccff_tail);
  endtask

  task automatic load(input logic [L-1:0] cfg);
    prog_en = 1'b1;
    for (int i = L - 1; i >= 0; i--) begin
      ccff_head = cfg[i];
      A         = N'($urandom);
      tb_val    = N'($urandom);
      tick();
      check_all("shift");
    end
    prog_en   = 1'b0;
    ccff_head = 1'b0;
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check_all(tag);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic v;
    RST = 1'b1; prog_en = 1'b0; ccff_head = 1'b0;
    A = '1; EVT_CLR = '0; tb_val = '1; tb_en = '1;
    #1 RST = 1'b0;
    m_reset();
    #11;
    check_all("reset");
    check("rst_tail", ccff_tail, 0);
    // All pads released: the bench pulling low must win against A=all ones.
    tb_val = '0;
    #1 check("rst_padz", PAD, 0);
    tb_val = '1;
    #1;
    @(negedge CK);
    RST = 1'b1;
    ticks(2, "rel");
    check("rst_y_ff", Y, 32'hFF);
    check("rst_evt0", EVT, 0);

    // ch0 output, registered.
    cfg1 = set_ch('0, 0, 1'b1, 1'b1, 2'b00);
    load(cfg1);
    for (int k = 0; k < 6; k++) begin
      A = N'($urandom);
      tb_val = N'($urandom);
      v = A[0];
      tick();
      check_all("oreg");
      check("oreg_lat", PAD[0], v);
    end

    // Shift the chain again: the previous pattern reappears on the tail.
    prog_en = 1'b1;
    for (int j = 0; j < L; j++) begin
      check("replay", ccff_tail, cfg1[L-1-j]);
      ccff_head = 1'($urandom);
      A = N'($urandom);
      tb_val = N'($urandom);
      tick();
      check_all("replay_sh");
    end
    prog_en = 1'b0;

    // ch3 rise, ch4 both, ch5 combinational output.
    cfg2 = set_ch('0, 3, 1'b0, 1'b0, 2'b01);
    cfg2 = set_ch(cfg2, 4, 1'b0, 1'b0, 2'b11);
    cfg2 = set_ch(cfg2, 5, 1'b1, 1'b0, 2'b00);
    load(cfg2);
    tb_val = '0; A = '0;
    ticks(4, "settle");
    EVT_CLR = '1;
    ticks(1, "clrall");
    EVT_CLR = '0;
    ticks(1, "settle");
    check("evt_clean", EVT, 0);

    tb_val[3] = 1'b1;
    ticks(2, "rise3");
    check("y3_lat", Y[3], 1);
    check("evt3_early", EVT[3], 0);
    ticks(1, "rise3");
    check("evt3_set", EVT[3], 1);
    EVT_CLR[3] = 1'b1;
    ticks(1, "clr3");
    EVT_CLR = '0;
    check("clr_alone", EVT[3], 0);
    tb_val[3] = 1'b0;
    ticks(4, "fall3");
    check("fall_noflag", EVT[3], 0);

    tb_val[4] = 1'b1;
    ticks(3, "both4");
    check("evt4_rise", EVT[4], 1);
    EVT_CLR[4] = 1'b1;
    ticks(1, "clr4");
    EVT_CLR = '0;
    tb_val[4] = 1'b0;
    ticks(3, "both4");
    check("evt4_fall", EVT[4], 1);

    // Set and clear in the same cycle: set wins.
    tb_val[3] = 1'b1;
    ticks(3, "sw");
    tb_val[3] = 1'b0;
    ticks(3, "sw");
    tb_val[3] = 1'b1;
    ticks(2, "sw");
    EVT_CLR[3] = 1'b1;
    ticks(1, "sw_clr");
    EVT_CLR = '0;
    check("set_wins", EVT[3], 1);
    EVT_CLR[3] = 1'b1;
    ticks(1, "clr3b");
    EVT_CLR = '0;
    check("clr_alone2", EVT[3], 0);

    // ch5 combinational output and readback.
    for (int k = 0; k < 4; k++) begin
      v = ~A[5];
      A[5] = v;
      #1 check("comb_pad5", PAD[5], v);
      ticks(2, "echo5");
      check("y5_echo", Y[5], v);
      ticks(1, "echo5");
    end

    // Reset in the middle of a shift aborts the load.
    prog_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      ccff_head = 1'($urandom);
      tick();
      check_all("abort_sh");
    end
    #2 RST = 1'b0;
    m_reset();
    tb_val = '0; A = '1; tb_en = '1;
    #1 check("abort_tail", ccff_tail, 0);
    check("abort_padz", PAD, 0);
    check("abort_y", Y, 0);
    prog_en = 1'b0;
    @(negedge CK);
    RST = 1'b1;
    load(cfg2);
    ticks(3, "reload");
    A[5] = 1'b0;
    #1 check("reload_pad5a", PAD[5], 0);
    A[5] = 1'b1;
    #1 check("reload_pad5b", PAD[5], 1);

    // Randomised traffic with occasional random reconfiguration.
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 39) == 0) load(L'($urandom));
      A       = N'($urandom);
      tb_val  = N'($urandom);
      EVT_CLR = N'($urandom & $urandom & $urandom);
      tick();
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
